// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state type, SPI mode encodings and sample-edge helper
package spi_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} spi_state_t;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    function automatic logic spi_sample_rising(input logic cpol, input logic cpha);
        return (cpol ^ cpha) == 1'b0;
    endfunction

endpackage

// File: rtl/spi_frame_rx_sync.sv
// spi_sync: single-bit synchroniser chain with configurable depth and reset value
module spi_sync #(
    parameter int   STAGES = 2,
    parameter logic RST    = 1'b0
) (
    input  logic clk,
    input  logic nreset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // shift the raw input through the flop chain
    always_ff @(posedge clk)
        if (!nreset) ff <= {STAGES{RST}};
        else ff <= {ff[STAGES-2:0], d};

    assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_frame_rx.sv
// spi_frame_rx: oversampled SPI frame receiver, commits exact-length frames; SPI_RX_ECHO_EN adds sdo readback of the last frame
module spi_frame_rx
    import spi_pkg::*;
#(
    parameter int WORD_W      = 16,
    parameter int NUM_WORDS   = 2,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          nreset,
    input  logic                          sck,
    input  logic                          sdi,
    input  logic                          load,
    output logic                          sdo,
    output logic [WORD_W*NUM_WORDS-1:0]   data,
    output logic                          frame_valid,
    output logic                          frame_err,
    output logic                          busy
);

    localparam int TOTAL = WORD_W * NUM_WORDS;
    localparam int CW    = $clog2(TOTAL + 2);
    localparam bit RISE  = spi_sample_rising(1'(CPOL), 1'(CPHA));

    spi_state_t       state, next_state;
    logic             sck_s, sdi_s, load_s, sck_p, load_p;
    logic             armed, rise_q, samp, load_rise, load_fall;
    logic [SYNC_STAGES:0] settle;
    logic [TOTAL-1:0] shreg;
    logic [CW-1:0]    cnt;

    spi_sync #(.STAGES(SYNC_STAGES), .RST(1'(CPOL))) u_sck  (.clk(clk), .nreset(nreset), .d(sck),  .q(sck_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RST(1'b0))     u_sdi  (.clk(clk), .nreset(nreset), .d(sdi),  .q(sdi_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RST(1'b0))     u_load (.clk(clk), .nreset(nreset), .d(load), .q(load_s));

    assign samp      = RISE ? (sck_s & ~sck_p) : (~sck_s & sck_p);
    assign load_rise = armed & load_s & ~load_p;
    assign load_fall = ~load_s & load_p;
    assign busy      = state != IDLE;

    // state register
    always_ff @(posedge clk)
        if (!nreset) state <= IDLE;
        else state <= next_state;

    // next state: start on pending rise, commit on load fall, commit lasts one cycle
    always_comb begin
        next_state = state;
        next_state = (state == IDLE && rise_q)     ? SHIFT  :
                     (state == SHIFT && load_fall) ? COMMIT :
                     (state == COMMIT)             ? IDLE   : state;
    end

    // edge history, start arming after reset, shifting and commit
    always_ff @(posedge clk)
        if (!nreset) begin
            sck_p       <= 1'(CPOL);
            load_p      <= 1'b0;
            settle      <= '0;
            armed       <= 1'b0;
            rise_q      <= 1'b0;
            shreg       <= '0;
            cnt         <= '0;
            data        <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            sck_p       <= sck_s;
            load_p      <= load_s;
            settle      <= {settle[SYNC_STAGES-1:0], 1'b1};
            if (settle[SYNC_STAGES] && !load_s) armed <= 1'b1;
            rise_q      <= load_rise | (rise_q & (state != IDLE));
            frame_valid <= state == COMMIT && cnt == CW'(TOTAL);
            frame_err   <= state == COMMIT && cnt != CW'(TOTAL);
            if (state == IDLE && rise_q) begin
                shreg <= '0;
                cnt   <= '0;
            end else if (state == SHIFT && samp) begin
                if (cnt < CW'(TOTAL)) shreg <= {shreg[TOTAL-2:0], sdi_s};
                if (cnt != CW'(TOTAL + 1)) cnt <= cnt + 1'b1;
            end
            if (state == COMMIT && cnt == CW'(TOTAL)) data <= shreg;
        end

`ifdef SPI_RX_ECHO_EN
    logic [TOTAL-1:0] tx;
    logic             tx_on, launch;

    assign launch = RISE ? (~sck_s & sck_p) : (sck_s & ~sck_p);
    assign sdo    = busy & tx_on & tx[TOTAL-1];

    // TX shifter loads the committed frame at start; CPHA=1 waits for the first launch edge
    always_ff @(posedge clk)
        if (!nreset) begin
            tx    <= '0;
            tx_on <= 1'b0;
        end else if (state == IDLE && rise_q) begin
            tx    <= data;
            tx_on <= CPHA == 0;
        end else if (state == SHIFT && launch) begin
            if (tx_on) tx <= tx << 1;
            tx_on <= 1'b1;
        end
`else
    assign sdo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_frame_rx.sv
// tb_spi_frame_rx: directed self-checking bench for spi_frame_rx in mode 0 (16x2) and mode 3 (8x4)
module tb_spi_frame_rx;

    logic        clk = 1'b0, nreset = 1'b0;
    logic        sck0 = 1'b0, sdi0 = 1'b0, load0 = 1'b0;
    logic        sck1 = 1'b1, sdi1 = 1'b0, load1 = 1'b0;
    logic        sdo0, fv0, fe0, busy0, sdo1, fv1, fe1, busy1;
    logic [31:0] data0, data1, cap = 32'h0;
    int          checks = 0, failures = 0;
    int          nv0 = 0, ne0 = 0, nv1 = 0, ne1 = 0;

    spi_frame_rx dut0 (
        .clk(clk), .nreset(nreset), .sck(sck0), .sdi(sdi0), .load(load0),
        .sdo(sdo0), .data(data0), .frame_valid(fv0), .frame_err(fe0), .busy(busy0)
    );

    spi_frame_rx #(.WORD_W(8), .NUM_WORDS(4), .CPOL(1), .CPHA(1)) dut1 (
        .clk(clk), .nreset(nreset), .sck(sck1), .sdi(sdi1), .load(load1),
        .sdo(sdo1), .data(data1), .frame_valid(fv1), .frame_err(fe1), .busy(busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fv0 === 1'b1) nv0 <= nv0 + 1;
        if (fe0 === 1'b1) ne0 <= ne0 + 1;
        if (fv1 === 1'b1) nv1 <= nv1 + 1;
        if (fe1 === 1'b1) ne1 <= ne1 + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bits(input int which, input logic [31:0] word, input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            b = (i < 32) ? word[31-i] : 1'b0;
            if (which == 0) begin
                sdi0 = b;
                wait_clk(4);
                cap = {cap[30:0], sdo0};
                sck0 = 1'b1;
                wait_clk(4);
                sck0 = 1'b0;
            end else begin
                sck1 = 1'b0;
                sdi1 = b;
                wait_clk(4);
                sck1 = 1'b1;
                wait_clk(4);
            end
        end
    endtask

    task automatic send_frame(input int which, input logic [31:0] word, input int n,
                              output int lat, output logic bmid);
        if (which == 0) load0 = 1'b1; else load1 = 1'b1;
        wait_clk(8);
        drive_bits(which, word, n);
        wait_clk(4);
        bmid = (which == 0) ? busy0 : busy1;
        if (which == 0) load0 = 1'b0; else load1 = 1'b0;
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (lat == 0 && ((which == 0) ? (fv0 | fe0) : (fv1 | fe1))) lat = k;
        end
    endtask

    task automatic test_reset;
        nreset = 1'b0;
        wait_clk(5);
        checks++; if (data0 !== 32'h0) begin failures++; $display("FAIL reset_data0 got=%h exp=0", data0); end
        checks++; if (fv0 !== 1'b0 || fe0 !== 1'b0) begin failures++; $display("FAIL reset_pulses0 got=%b%b exp=00", fv0, fe0); end
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy0 got=%b exp=0", busy0); end
        checks++; if (sdo0 !== 1'b0) begin failures++; $display("FAIL reset_sdo0 got=%b exp=0", sdo0); end
        checks++; if (data1 !== 32'h0 || busy1 !== 1'b0) begin failures++; $display("FAIL reset_dut1 got=%h/%b exp=0/0", data1, busy1); end
        nreset = 1'b1;
        wait_clk(10);
    endtask

    task automatic test_good_frame;
        int v, e, lat;
        logic bm;
        v = nv0; e = ne0;
        send_frame(0, 32'h01020304, 32, lat, bm);
        checks++; if (data0 !== 32'h01020304) begin failures++; $display("FAIL good_data got=%h exp=01020304", data0); end
        checks++; if (nv0 - v !== 1 || ne0 - e !== 0) begin failures++; $display("FAIL good_pulses got=v%0d e%0d exp=v1 e0", nv0 - v, ne0 - e); end
        checks++; if (lat !== 4) begin failures++; $display("FAIL good_latency got=%0d exp=4", lat); end
        checks++; if (bm !== 1'b1 || busy0 !== 1'b0) begin failures++; $display("FAIL good_busy got=%b/%b exp=1/0", bm, busy0); end
    endtask

    task automatic test_short_frame;
        int v, e, lat;
        logic bm;
        send_frame(0, 32'hDEADBEEF, 32, lat, bm);
        checks++; if (data0 !== 32'hDEADBEEF) begin failures++; $display("FAIL prior_data got=%h exp=deadbeef", data0); end
        v = nv0; e = ne0;
        send_frame(0, 32'h01020304, 31, lat, bm);
        checks++; if (data0 !== 32'hDEADBEEF) begin failures++; $display("FAIL short_data got=%h exp=deadbeef", data0); end
        checks++; if (nv0 - v !== 0 || ne0 - e !== 1) begin failures++; $display("FAIL short_pulses got=v%0d e%0d exp=v0 e1", nv0 - v, ne0 - e); end
        checks++; if (lat !== 4) begin failures++; $display("FAIL short_latency got=%0d exp=4", lat); end
    endtask

    task automatic test_overrun;
        int v, e, lat;
        logic bm;
        v = nv0; e = ne0;
        send_frame(0, 32'h01020304, 33, lat, bm);
        checks++; if (data0 !== 32'hDEADBEEF) begin failures++; $display("FAIL overrun_data got=%h exp=deadbeef", data0); end
        checks++; if (nv0 - v !== 0 || ne0 - e !== 1) begin failures++; $display("FAIL overrun_pulses got=v%0d e%0d exp=v0 e1", nv0 - v, ne0 - e); end
        v = nv0; e = ne0;
        send_frame(0, 32'h0, 0, lat, bm);
        checks++; if (nv0 - v !== 0 || ne0 - e !== 1) begin failures++; $display("FAIL zero_pulses got=v%0d e%0d exp=v0 e1", nv0 - v, ne0 - e); end
    endtask

    task automatic test_mode3;
        int v, e, lat;
        logic bm;
        v = nv1; e = ne1;
        send_frame(1, 32'hA5C30FF0, 32, lat, bm);
        checks++; if (data1 !== 32'hA5C30FF0) begin failures++; $display("FAIL mode3_data got=%h exp=a5c30ff0", data1); end
        checks++; if (nv1 - v !== 1 || ne1 - e !== 0) begin failures++; $display("FAIL mode3_pulses got=v%0d e%0d exp=v1 e0", nv1 - v, ne1 - e); end
        checks++; if (lat !== 4) begin failures++; $display("FAIL mode3_latency got=%0d exp=4", lat); end
    endtask

    task automatic test_back_to_back;
        int v, e;
        v = nv0; e = ne0;
        load0 = 1'b1;
        wait_clk(8);
        drive_bits(0, 32'h11112222, 32);
        wait_clk(4);
        load0 = 1'b0;
        wait_clk(1);
        load0 = 1'b1;
        wait_clk(8);
        checks++; if (data0 !== 32'h11112222 || nv0 - v !== 1) begin failures++; $display("FAIL b2b_first got=%h v%0d exp=11112222 v1", data0, nv0 - v); end
        checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL b2b_restart_busy got=%b exp=1", busy0); end
        drive_bits(0, 32'h33334444, 32);
        wait_clk(4);
        load0 = 1'b0;
        wait_clk(12);
        checks++; if (data0 !== 32'h33334444) begin failures++; $display("FAIL b2b_second got=%h exp=33334444", data0); end
        checks++; if (nv0 - v !== 2 || ne0 - e !== 0) begin failures++; $display("FAIL b2b_pulses got=v%0d e%0d exp=v2 e0", nv0 - v, ne0 - e); end
    endtask

    task automatic test_reset_mid;
        int v, e, lat;
        logic bm;
        load0 = 1'b1;
        wait_clk(8);
        drive_bits(0, 32'hFFFFFFFF, 10);
        v = nv0; e = ne0;
        nreset = 1'b0;
        wait_clk(3);
        checks++; if (data0 !== 32'h0 || busy0 !== 1'b0) begin failures++; $display("FAIL midreset_state got=%h/%b exp=0/0", data0, busy0); end
        nreset = 1'b1;
        wait_clk(10);
        drive_bits(0, 32'hFFFFFFFF, 4);
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL stale_load_busy got=%b exp=0", busy0); end
        wait_clk(4);
        load0 = 1'b0;
        wait_clk(12);
        checks++; if (nv0 - v !== 0 || ne0 - e !== 0 || data0 !== 32'h0) begin failures++; $display("FAIL midreset_quiet got=v%0d e%0d d=%h exp=v0 e0 d=0", nv0 - v, ne0 - e, data0); end
        send_frame(0, 32'h12345678, 32, lat, bm);
        checks++; if (data0 !== 32'h12345678 || lat !== 4) begin failures++; $display("FAIL after_reset_frame got=%h lat%0d exp=12345678 lat4", data0, lat); end
    endtask

    task automatic test_echo;
        int lat;
        logic bm;
        logic [31:0] exp;
`ifdef SPI_RX_ECHO_EN
        exp = 32'hCAFEF00D;
`else
        exp = 32'h0;
`endif
        send_frame(0, 32'hCAFEF00D, 32, lat, bm);
        checks++; if (data0 !== 32'hCAFEF00D) begin failures++; $display("FAIL echo_prior got=%h exp=cafef00d", data0); end
        cap = 32'h0;
        send_frame(0, 32'h0, 32, lat, bm);
        checks++; if (cap !== exp) begin failures++; $display("FAIL echo_stream got=%h exp=%h", cap, exp); end
        checks++; if (data0 !== 32'h0 || sdo0 !== 1'b0) begin failures++; $display("FAIL echo_after got=%h/%b exp=0/0", data0, sdo0); end
    endtask

    initial begin
        test_reset;
        test_good_frame;
        test_short_frame;
        test_overrun;
        test_mode3;
        test_back_to_back;
        test_reset_mid;
        test_echo;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
